// File: rtl/rv32_ifid_queue.sv
// Fetch-to-decode instruction queue: circular FIFO of {pc, instr} with NOP fill, flush and halt detection.
// Optional same-cycle bypass of an empty queue is enabled by defining RV32_IFID_BYPASS_EN.
module rv32_ifid_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     if_valid,
    input  logic [31:0]              if_pc,
    input  logic [31:0]              if_instr,
    output logic                     if_ready,
    input  logic                     id_stall,
    output logic [31:0]              code_bus,
    output logic [31:0]              id_pc,
    output logic                     id_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     halted
);
    localparam int          PW        = $clog2(DEPTH);
    localparam int          CW        = PW + 1;
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          halted_q, halted_d;
    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];

    logic          push, pop, head_is_halt, byp, wr_en;
    logic [31:0]   head_pc, head_instr;

    always_comb begin
        byp = 1'b0;
`ifdef RV32_IFID_BYPASS_EN
        byp = (count_q == '0) & if_valid & ~flush & ~halted_q;
`endif
        head_pc    = byp ? if_pc    : pc_mem_q[rd_ptr_q];
        head_instr = byp ? if_instr : instr_mem_q[rd_ptr_q];

        id_valid     = (count_q != '0) | byp;
        code_bus     = id_valid ? head_instr : NOP_WORD;
        id_pc        = id_valid ? head_pc : 32'h0;
        // Readiness deliberately ignores id_stall: a full queue never admits a push.
        if_ready     = (count_q != FULL) & ~halted_q & ~flush;
        push         = if_valid & if_ready;
        head_is_halt = id_valid & (head_instr == HALT_WORD);
        pop          = id_valid & ~id_stall & ~halted_q & ~head_is_halt;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        wr_en    = 1'b0;
        halted_d = halted_q | head_is_halt;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else if (!(byp && pop)) begin
            // A bypassed word consumed in the same cycle never touches storage.
            if (push) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            halted_q <= halted_d;
        end
    end

    // Storage is not reset; empty-state reads are masked by the NOP substitution.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem_q[wr_ptr_q]    <= if_pc;
            instr_mem_q[wr_ptr_q] <= if_instr;
        end
    end

    assign count  = count_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_rv32_ifid_queue.sv
// Bench for rv32_ifid_queue: queue-level reference model checked every cycle plus directed literal checks.
module tb_rv32_ifid_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef RV32_IFID_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_pc = '0;
    logic [31:0] if_instr = '0;
    logic        if_ready;
    logic        id_stall = 1'b0;
    logic [31:0] code_bus;
    logic [31:0] id_pc;
    logic        id_valid;
    logic [2:0]  count;
    logic        halted;

    int total = 0;
    int bad   = 0;

    rv32_ifid_queue #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_instr (if_instr),
        .if_ready (if_ready),
        .id_stall (id_stall),
        .code_bus (code_bus),
        .id_pc    (id_pc),
        .id_valid (id_valid),
        .count    (count),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    // Reference model: an ordinary queue of {pc, instr} plus a halt flag.
    logic [63:0] mq[$];
    bit          mhalt;

    function automatic void model_out(output bit ev, output logic [31:0] ec, output logic [31:0] ep,
                                      output bit erdy, output int ecnt, output bit byp);
        logic [63:0] head;
        byp  = BYP && (mq.size() == 0) && if_valid && !flush && !mhalt;
        ev   = (mq.size() != 0) || byp;
        head = (mq.size() != 0) ? mq[0] : {if_pc, if_instr};
        ec   = ev ? head[31:0] : NOP;
        ep   = ev ? head[63:32] : 32'h0;
        erdy = (mq.size() != DEPTH) && !mhalt && !flush;
        ecnt = mq.size();
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    bit          u_ev, u_erdy, u_byp, u_hh, u_pop, u_push;
    logic [31:0] u_ec, u_ep;
    int          u_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mhalt = 1'b0;
        end else begin
            model_out(u_ev, u_ec, u_ep, u_erdy, u_cnt, u_byp);
            u_hh   = u_ev && (u_ec == 32'hFFFF_FFFF);
            u_pop  = u_ev && !id_stall && !mhalt && !u_hh;
            u_push = if_valid && u_erdy;
            if (flush) begin
                mq.delete();
            end else if (!(u_byp && u_pop)) begin
                if (u_pop) void'(mq.pop_front());
                if (u_push) mq.push_back({if_pc, if_instr});
            end
            if (u_hh) mhalt = 1'b1;
        end
    end

    bit          c_ev, c_erdy, c_byp;
    logic [31:0] c_ec, c_ep;
    int          c_cnt;

    always @(negedge clk) begin
        if (rst_n) begin
            model_out(c_ev, c_ec, c_ep, c_erdy, c_cnt, c_byp);
            check("id_valid", 32'(id_valid), 32'(c_ev));
            check("code_bus", code_bus, c_ec);
            check("id_pc", id_pc, c_ep);
            check("if_ready", 32'(if_ready), 32'(c_erdy));
            check("count", 32'(count), 32'(c_cnt));
            check("halted", 32'(halted), 32'(mhalt));
        end
    end

    task automatic drive(input bit f, input bit v, input logic [31:0] pc, input logic [31:0] ins,
                         input bit st);
        @(posedge clk);
        #1;
        flush    = f;
        if_valid = v;
        if_pc    = pc;
        if_instr = ins;
        id_stall = st;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    logic [31:0] fill_i [4] = '{32'h0050_0093, 32'h0060_0113, 32'h0020_81B3, 32'h4020_8233};

    initial begin
        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_code_bus", code_bus, 32'h0000_0013);
        check("rst_count", 32'(count), 32'd0);
        check("rst_if_ready", 32'(if_ready), 32'd1);
        rst_n = 1'b1;

        // Fill under stall, then drain in order
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 32'(4 * i), fill_i[i], 1'b1);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        settle();
        check("fill_count", 32'(count), 32'd4);
        check("fill_if_ready", 32'(if_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            settle();
            check("drain_code", code_bus, (i < 4) ? fill_i[i] : 32'h0000_0013);
            check("drain_pc", id_pc, (i < 4) ? 32'(4 * i) : 32'h0);
        end

        // Continuous push+pop across pointer wrap
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 32'h100 + 32'(4 * i), 32'h0010_0093 + (32'(i) << 20), 1'b0);
            settle();
            if (i >= 1) check("wrap_count", 32'(count), BYP ? 32'd0 : 32'd1);
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        // Asynchronous reset in the middle of operation
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 32'h500 + 32'(4 * i), 32'h0000_0113, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        settle();
        check("pre_rst_count", 32'(count), 32'd3);
        rst_n = 1'b0;
        #1;
        check("midrst_id_valid", 32'(id_valid), 32'd0);
        check("midrst_code_bus", code_bus, 32'h0000_0013);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_if_ready", 32'(if_ready), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Flush discards contents and the same-cycle push
        drive(1'b0, 1'b1, 32'h10, 32'h0010_0213, 1'b1);
        drive(1'b0, 1'b1, 32'h14, 32'h0020_0213, 1'b1);
        drive(1'b0, 1'b1, 32'h18, 32'h0030_0213, 1'b1);
        drive(1'b1, 1'b1, 32'h40, 32'h0090_0293, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        settle();
        check("flush_count", 32'(count), 32'd0);
        check("flush_code", code_bus, 32'h0000_0013);
        drive(1'b0, 1'b1, 32'h80, 32'h00A0_0313, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        settle();
        check("post_flush_pc", id_pc, 32'h80);
        check("post_flush_code", code_bus, 32'h00A0_0313);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        // Push-to-output latency
        drive(1'b0, 1'b1, 32'h200, 32'h0070_0193, 1'b0);
        settle();
        check("lat_code_c0", code_bus, BYP ? 32'h0070_0193 : 32'h0000_0013);
        check("lat_count_c0", 32'(count), 32'd0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        settle();
        check("lat_code_c1", code_bus, BYP ? 32'h0000_0013 : 32'h0070_0193);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        // Halt word freezes the queue
        drive(1'b0, 1'b1, 32'h300, 32'h0050_0093, 1'b0);
        drive(1'b0, 1'b1, 32'h304, 32'hFFFF_FFFF, 1'b0);
        drive(1'b0, 1'b1, 32'h308, 32'h0060_0113, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 32'h30C, 32'h0000_0013, 1'b0);
            settle();
            check("halt_code", code_bus, 32'hFFFF_FFFF);
            check("halt_flag", 32'(halted), 32'd1);
            check("halt_if_ready", 32'(if_ready), 32'd0);
            check("halt_count", 32'(count), BYP ? 32'd1 : 32'd2);
        end
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        settle();
        check("halt_flush_code", code_bus, 32'h0000_0013);
        check("halt_flush_flag", 32'(halted), 32'd1);
        check("halt_flush_count", 32'(count), 32'd0);
        drive(1'b0, 1'b1, 32'h400, 32'h0000_0093, 1'b0);
        settle();
        check("halt_no_push", 32'(if_ready), 32'd0);

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("halt_rst_clear", 32'(halted), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv32_ifid_queue.md
Name: rv32_ifid_queue

Overview:
Instruction buffer between the fetch stage and the decode control unit, carrying {pc, instruction} pairs in a small circular FIFO.
- Presents the head instruction on code_bus, which feeds the decoder directly.
- Absorbs decode stalls and drains on branch/jump redirect (flush).
- Inserts a canonical NOP (ADDI x0,x0,0 = 32'h0000_0013) whenever it has nothing valid.
- Detects the halt word 32'hFFFF_FFFF at the head and freezes.

Parameters:
DEPTH, 4, number of entries; power of two, >= 2.
NOP_WORD, 32'h0000_0013, word driven on code_bus when no valid entry.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  redirect from EX (branch taken / JAL / JALR); discard all entries
if_valid  input  1  fetch offers if_pc/if_instr this cycle
if_pc  input  32  PC of offered instruction
if_instr  input  32  offered instruction word
if_ready  output  1  queue accepts a push this cycle
id_stall  input  1  decode/hazard stall; head must not advance
code_bus  output  32  head instruction to the decoder, or NOP_WORD
id_pc  output  32  PC of head entry, 0 when not valid
id_valid  output  1  head entry valid
count  output  $clog2(DEPTH)+1  occupancy
halted  output  1  sticky halt flag

Behaviour:
- Reset (async, rst_n=0): wr_ptr=0, rd_ptr=0, count=0, halted=0. Outputs: id_valid=0, code_bus=NOP_WORD, id_pc=0, if_ready=1. Storage contents are don't-care.
- Definitions:
  - push = if_valid & if_ready.
  - pop = id_valid & ~id_stall & ~halted & ~head_is_halt.
  - head_is_halt = id_valid & (mem[rd_ptr].instr == 32'hFFFF_FFFF).
- if_ready = (count != DEPTH) & ~halted & ~flush. It has no combinational dependence on id_stall, so when full a simultaneous pop does not admit a push.
- Outputs are registered storage read combinationally at rd_ptr:
  - id_valid = (count != 0).
  - code_bus = id_valid ? head instr : NOP_WORD.
  - id_pc = id_valid ? head pc : 0.
- Push: write {if_pc, if_instr} at wr_ptr and advance wr_ptr. Visible at the head on the next cycle when the queue was empty, so push-to-output latency is 1 cycle.
- Pop: advance rd_ptr.
- Pointers wrap modulo DEPTH using the low log2(DEPTH) bits.
- count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- flush (synchronous, highest priority):
  - Next edge: rd_ptr=wr_ptr=0, count=0.
  - A same-cycle push or pop is discarded.
  - Following cycle: id_valid=0, code_bus=NOP_WORD.
  - flush does not clear halted.
- Halt:
  - When head_is_halt, the entry is never popped. code_bus keeps showing 32'hFFFF_FFFF so the decoder holds pc_enable low.
  - On the next edge halted is set to 1. It is sticky until rst_n.
  - While halted=1: no push, no pop, count frozen.
  - If flush asserts while halted, the queue empties but halted stays 1 and code_bus becomes NOP_WORD.
- id_stall with an empty queue has no effect.
- Storage holds no X on outputs: the NOP substitution covers empty state.

Optional Feature:
RV32_IFID_BYPASS_EN.
- Defined: when count==0 and if_valid=1 and ~flush and ~halted, the input is presented combinationally on the same cycle:
  - code_bus=if_instr, id_pc=if_pc, id_valid=1.
  - If the entry is also popped that cycle (~id_stall, not halt word), it is not written and pointers/count are unchanged.
  - Otherwise it is written normally.
  - Push-to-output latency becomes 0.
- Undefined: no bypass path; latency is always 1 cycle as above.

Test Plan:
- Reset: hold rst_n=0 mid-operation with count=3 -> immediately id_valid=0, code_bus=32'h0000_0013, count=0, if_ready=1.
- Fill: DEPTH=4, id_stall=1, push PCs 0x00,0x04,0x08,0x0C with instrs 0x00500093,0x00600113,0x002081B3,0x40208233 -> count=4, if_ready=0. Then drop id_stall -> code_bus shows them in order over 4 cycles, id_pc 0x00..0x0C, then NOP.
- Wrap-around: continuous push+pop with id_stall=0 for 10 instructions -> count constant at 1, output order matches input order across pointer wrap, no drops.
- Flush: count=3, assert flush together with if_valid=1 (pc 0x40) -> next cycle count=0, code_bus=NOP. The 0x40 entry is never seen; a push of pc 0x80 the following cycle appears as the head.
- Halt: push 0x00500093 then 0xFFFFFFFF then 0x00600113 -> first pops normally. code_bus then holds 0xFFFFFFFF indefinitely with id_stall=0, halted=1 one cycle later, if_ready=0, count frozen at 2. Only rst_n clears it.
- Bypass (macro defined): empty queue, if_valid=1 with instr 0x00700193, id_stall=0 -> code_bus=0x00700193 in the same cycle, count stays 0. Without the macro it appears one cycle later.
